async_req_arbiter: RTL and testbench
====================================

Name: async_req_arbiter

Overview:
- Round-robin arbiter for N_REQ requesters that live in foreign or asynchronous clock domains.
- Each requester uses a 4-phase level handshake (req_async / ack). Every req_async line passes through its own internal STAGES-deep synchronizer chain.
- Synchronized requests are arbitrated and offered one at a time to a single consumer in the clk domain over a valid/ready port.
- Sits at the boundary between async peripherals and core-domain logic. It sequences which synchronized request is serviced and when acks are returned.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- STAGES, 2: synchronizer flops per req_async line, minimum 2.
- IDX_W, $clog2(N_REQ): width of grant_idx.

Ports:
- clk  input  1  destination clock; all state is in this domain.
- rst  input  1  asynchronous, active-high reset.
- req_async  input  N_REQ  per-requester async request level; held high until the matching ack is seen high.
- ack  output  N_REQ  per-requester acknowledge, registered; the requester synchronizes it back into its own domain.
- grant_valid  output  1  a granted request is offered; registered.
- grant_idx  output  IDX_W  index of the offered requester; registered.
- grant_ready  input  1  consumer accepts the offered grant this cycle.
- busy  output  1  OR of (channel state != IDLE) over all channels; registered.

Behaviour:
- Reset (asynchronous, active-high, immediate):
  - synchronizer flops = 0, all channel states = IDLE, ack = 0.
  - grant_valid = 0, grant_idx = 0, rr_ptr = 0, busy = 0.
  - Reset takes effect without a clock edge, including mid-handshake.
- Synchronizer:
  - req_s[i] equals req_async[i] as sampled STAGES clk edges earlier.
  - No other logic reads req_async directly.
- Per-channel FSM, states IDLE, PENDING, ACKED, updated on every clk edge:
  - IDLE -> PENDING when req_s = 1.
  - PENDING -> IDLE when req_s = 0 and the channel is not the one currently offered (requester abort).
  - PENDING -> ACKED on the edge where grant_valid & grant_ready & grant_idx = i. ack[i] <= 1 on the same edge.
  - ACKED -> IDLE when req_s = 0. ack[i] <= 0 on the same edge.
  - ack[i] = 1 exactly while the channel is in ACKED.
- Offered channel:
  - Once offered, a channel cannot abort; the grant is held until accepted.
  - If req_s is already low at acceptance, the channel still enters ACKED, then returns to IDLE on the next edge. ack is a 1-cycle pulse in that case.
- Arbiter:
  - When grant_valid = 0 and at least one channel is PENDING, on the next edge set grant_valid <= 1 and grant_idx <= first PENDING channel.
  - The search starts at rr_ptr, runs in ascending index order and wraps from N_REQ-1 to 0.
  - While grant_valid = 1 and grant_ready = 0: grant_valid and grant_idx hold stable. New or higher-priority requests do not change them.
  - On accept (grant_valid & grant_ready): grant_valid <= 0 and rr_ptr <= (grant_idx + 1) mod N_REQ.
  - The next grant appears no earlier than one edge later, so there is at least one idle cycle between grants.
  - grant_ready is ignored while grant_valid = 0.
- Latency, with req_async rising just before edge 1:
  - req_s high after edge STAGES.
  - PENDING after edge STAGES+1.
  - grant_valid after edge STAGES+2.
  - With grant_ready high, ack high after edge STAGES+3.
- Release: req_async falling just before edge k gives ack low after edge k+STAGES.
- Simultaneous events:
  - Accepting grant to channel i and a new PENDING on channel j on the same edge: j becomes eligible for the next selection.
  - Channel i re-raising req after ack falls is treated as a fresh request.
- Assertion: the FSM never enters ACKED without a prior accepted grant.

Test Plan:
- Single request, STAGES=2, grant_ready=1:
  - raise req_async[1] before edge 1 -> grant_valid=1 and grant_idx=1 after edge 4; ack[1]=1 after edge 5.
  - drop req_async[1] before edge 10 -> ack[1]=0 after edge 12; busy=0.
- All four requests raised together, grant_ready=1:
  - grants issued in order 0,1,2,3 with one idle cycle between each.
  - holding all reqs high gives no second grant.
  - after all reqs drop and are re-raised, order is 0,1,2,3 again (rr_ptr=0).
- Backpressure:
  - req[2] offered, grant_ready=0 for 10 cycles, raise req[0] -> grant_idx stays 2 and grant_valid stays 1 throughout.
  - when grant_ready is asserted -> ack[2] rises; next grant is idx 0.
- Abort: req[3] raised while the grant for channel 1 is held, then req[3] dropped before acceptance -> channel 3 returns to IDLE, is never granted, and ack[3] stays 0.
- Wrap-around: rr_ptr=3 (after granting 2), requests pending on 0 and 3 -> grant 3 first, then 0.
- Reset mid-operation:
  - ack[2]=1 and grant_valid=1, then pulse rst between edges -> ack=0, grant_valid=0 and busy=0 immediately, with no edge needed.
  - with req[2] still high after rst is released -> grant_idx=2 offered after edge STAGES+2.

Source files
------------

// File: rtl/async_req_arbiter_if.sv
// Bundle of the arbiter's bus-side signals.
//
// Ports carried:
//   req_async   : per-requester 4-phase request level, driven from foreign domains
//   ack         : per-requester acknowledge, registered in the arbiter's clk domain
//   grant_valid : a grant is offered to the consumer
//   grant_idx   : index of the offered requester
//   grant_ready : consumer accepts the offered grant
//   busy        : some channel is not IDLE
//
// Handshake: a grant transfers on a clk edge where grant_valid and grant_ready
// are both high; grant_valid/grant_idx stay stable until that edge, and
// grant_ready has no meaning while grant_valid is low.
interface async_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_async;
    logic [N_REQ-1:0] ack;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_ready;
    logic             busy;

    // Arbiter side
    modport slave (
        input  req_async,
        input  grant_ready,
        output ack,
        output grant_valid,
        output grant_idx,
        output busy
    );

    // Requester/consumer side
    modport master (
        output req_async,
        output grant_ready,
        input  ack,
        input  grant_valid,
        input  grant_idx,
        input  busy
    );
endinterface

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for requesters in foreign clock domains.
//
// Each req_async line is synchronized through STAGES flops, then tracked by a
// per-channel IDLE/PENDING/ACKED state machine. Pending channels are offered
// one at a time to a single consumer over grant_valid/grant_ready; acceptance
// moves the channel to ACKED and raises its ack, which drops again once the
// synchronized request falls (4-phase handshake).
//
// Ports:
//   clk  : destination clock, all state lives here
//   rst  : asynchronous active-high reset
//   bus  : async_req_arbiter_if.slave (req_async, ack, grant_valid,
//          grant_idx, grant_ready, busy)
module async_req_arbiter #(
    parameter int N_REQ  = 4,
    parameter int STAGES = 2,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input logic                clk,
    input logic                rst,
    async_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACKED   = 2'd2
    } ch_state_t;

    // Synchronizer chains, one bit per requester in each stage
    logic [N_REQ-1:0] sync_q [STAGES];
    logic [N_REQ-1:0] req_s;

    ch_state_t        state_q [N_REQ];
    ch_state_t        state_d [N_REQ];
    logic [N_REQ-1:0] ack_q;
    logic             busy_q;
    logic             busy_d;

    logic             grant_valid_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_next;
    logic             accept;

    logic [N_REQ-1:0] eligible;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.req_async;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign req_s  = sync_q[STAGES-1];
    assign accept = grant_valid_q & bus.grant_ready;

    // ------------------------------------------------------------------
    // Per-channel FSMs: next state
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (req_s[i]) state_d[i] = PENDING;
                end
                PENDING: begin
                    // An offered channel is committed: it cannot abort, only
                    // be accepted (even if its request has already fallen).
                    if (accept && grant_idx_q == IDX_W'(i)) begin
                        state_d[i] = ACKED;
                    end else if (!req_s[i] &&
                                 !(grant_valid_q && grant_idx_q == IDX_W'(i))) begin
                        state_d[i] = IDLE;
                    end
                end
                ACKED: begin
                    if (!req_s[i]) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
            if (state_d[i] != IDLE) busy_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel FSMs: state, ack and busy registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= IDLE;
            end
            ack_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= state_d[i];
                // ack mirrors the registered state: high exactly in ACKED
                ack_q[i]   <= (state_d[i] == ACKED);
            end
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    // A PENDING channel whose request has already fallen is about to abort on
    // this edge, so it is not offered.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = (state_q[i] == PENDING) && req_s[i];
        end
    end

    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        if (int'(grant_idx_q) == N_REQ - 1) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_idx_q + IDX_W'(1);
        end
    end

    // Accept always clears grant_valid, so a fresh grant can only be loaded on
    // a later edge: there is at least one idle cycle between grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
        end else if (accept) begin
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= rr_ptr_next;
        end else if (!grant_valid_q && pick_found) begin
            grant_valid_q <= 1'b1;
            grant_idx_q   <= pick_idx;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.busy        = busy_q;

    // A channel may only enter ACKED on the edge its grant is accepted.
    for (genvar g = 0; g < N_REQ; g++) begin : g_chk
        a_acked_needs_accept: assert property (
            @(posedge clk) disable iff (rst)
            (state_d[g] == ACKED && state_q[g] != ACKED) |->
            (accept && grant_idx_q == IDX_W'(g))
        );
    end

endmodule

// File: tb/tb_async_req_arbiter.sv
module tb_async_req_arbiter;

    localparam int N_REQ  = 4;
    localparam int STAGES = 2;
    localparam int IDX_W  = 2;

    logic clk;
    logic rst;

    async_req_arbiter_if #(.N_REQ(N_REQ), .IDX_W(IDX_W)) bus ();

    async_req_arbiter #(
        .N_REQ (N_REQ),
        .STAGES(STAGES),
        .IDX_W (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [IDX_W-1:0] exp_q[$];

    typedef struct {
        logic [N_REQ-1:0] req;
        logic             ready;
        logic             exp_valid;
        logic [IDX_W-1:0] exp_idx;
        logic [N_REQ-1:0] exp_ack;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[13];

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.req_async   = '0;
        bus.grant_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string name, input int budget, output logic [IDX_W-1:0] idx);
        int n;
        n   = 0;
        idx = '0;
        while (bus.grant_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (bus.grant_valid !== 1'b1) begin
            check({name, "_timeout"}, 32'(bus.grant_valid), 32'd1);
        end else begin
            idx = bus.grant_idx;
        end
    endtask

    task automatic wait_ack(input string name, input int ch, input int budget);
        int n;
        n = 0;
        while (bus.ack[ch] !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(bus.ack[ch]), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || bus.ack !== '0) && n < budget) begin
            step();
            n++;
        end
        check(name, {27'd0, bus.busy, bus.ack}, 32'd0);
    endtask

    // All four requests high with grant_ready=1: grants must match exp_q order,
    // never on consecutive cycles, and no further grant while reqs stay high.
    task automatic run_all_four(input string name);
        logic prev_valid;
        int   n;
        bus.grant_ready = 1'b1;
        bus.req_async   = 4'b1111;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        prev_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
            if (bus.grant_valid === 1'b1) begin
                check({name, "_order"}, 32'(bus.grant_idx), 32'(exp_q.pop_front()));
                check({name, "_gap"}, 32'(prev_valid), 32'd0);
            end
            prev_valid = bus.grant_valid;
        end
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.grant_valid === 1'b1) n++;
        end
        check({name, "_no_regrant"}, 32'(n), 32'd0);
        check({name, "_all_acked"}, 32'(bus.ack), 32'hf);
        bus.req_async = '0;
        wait_idle({name, "_idle"}, 20);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [IDX_W-1:0] g;
        int n_seen;
        n_cmp = 0;
        n_bad = 0;

        // Single request on channel 1: inputs before edge k, expectations after it
        vecs[0]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[3]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1};
        vecs[4]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[5]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[6]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[7]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[8]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[10] = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};

        // Reset state
        rst             = 1'b1;
        bus.req_async   = 4'b1111;
        bus.grant_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_idx",   32'(bus.grant_idx),   32'd0);
        check("rst_ack",   32'(bus.ack),         32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);

        // Single request table
        do_reset();
        for (int k = 0; k < 13; k++) begin
            bus.req_async   = vecs[k].req;
            bus.grant_ready = vecs[k].ready;
            step();
            check($sformatf("single_valid_e%0d", k + 1), 32'(bus.grant_valid), 32'(vecs[k].exp_valid));
            check($sformatf("single_ack_e%0d", k + 1),   32'(bus.ack),         32'(vecs[k].exp_ack));
            check($sformatf("single_busy_e%0d", k + 1),  32'(bus.busy),        32'(vecs[k].exp_busy));
            if (vecs[k].exp_valid) begin
                check($sformatf("single_idx_e%0d", k + 1), 32'(bus.grant_idx), 32'(vecs[k].exp_idx));
            end
        end

        // All four together, twice; rr_ptr wraps back to 0 after granting 3
        do_reset();
        run_all_four("all4_first");
        run_all_four("all4_again");

        // Backpressure on channel 2, then a new request on channel 0
        do_reset();
        bus.req_async = 4'b0100;
        wait_grant("bp_grant", 10, g);
        check("bp_idx", 32'(g), 32'd2);
        bus.req_async = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("bp_hold_valid_%0d", c), 32'(bus.grant_valid), 32'd1);
            check($sformatf("bp_hold_idx_%0d", c),   32'(bus.grant_idx),   32'd2);
        end
        bus.grant_ready = 1'b1;
        step();
        check("bp_ack2", 32'(bus.ack), 32'b0100);
        check("bp_valid_drop", 32'(bus.grant_valid), 32'd0);
        wait_grant("bp_next", 10, g);
        check("bp_next_idx", 32'(g), 32'd0);
        bus.req_async = '0;
        wait_idle("bp_idle", 20);

        // Abort: channel 3 comes and goes while channel 1's grant is held
        do_reset();
        bus.req_async = 4'b0010;
        wait_grant("abort_grant", 10, g);
        check("abort_idx", 32'(g), 32'd1);
        bus.req_async = 4'b1010;
        repeat (4) step();
        bus.req_async = 4'b0010;
        repeat (4) step();
        bus.grant_ready = 1'b1;
        step();
        check("abort_ack1", 32'(bus.ack), 32'b0010);
        n_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.grant_valid === 1'b1) n_seen++;
            if (bus.ack[3] !== 1'b0) n_seen++;
        end
        check("abort_ch3_quiet", 32'(n_seen), 32'd0);
        bus.req_async = '0;
        wait_idle("abort_idle", 20);

        // Wrap-around: grant 2 first so rr_ptr=3, then 0 and 3 together
        do_reset();
        bus.grant_ready = 1'b1;
        bus.req_async   = 4'b0100;
        wait_ack("wrap_ack2", 2, 12);
        bus.req_async = '0;
        wait_idle("wrap_idle1", 20);
        bus.req_async = 4'b1001;
        wait_grant("wrap_first", 12, g);
        check("wrap_first_idx", 32'(g), 32'd3);
        step();
        wait_grant("wrap_second", 12, g);
        check("wrap_second_idx", 32'(g), 32'd0);
        bus.req_async = '0;
        wait_idle("wrap_idle2", 20);

        // Reset mid-operation: ack[2]=1 with a grant for 0 held
        do_reset();
        bus.grant_ready = 1'b1;
        bus.req_async   = 4'b0100;
        wait_ack("mid_ack2", 2, 12);
        bus.grant_ready = 1'b0;
        bus.req_async   = 4'b0101;
        wait_grant("mid_grant0", 12, g);
        check("mid_grant0_idx", 32'(g), 32'd0);
        check("mid_ack2_held", 32'(bus.ack), 32'b0100);
        rst = 1'b1;
        #1;
        check("mid_rst_ack",   32'(bus.ack),         32'd0);
        check("mid_rst_valid", 32'(bus.grant_valid), 32'd0);
        check("mid_rst_busy",  32'(bus.busy),        32'd0);
        bus.req_async = 4'b0100;
        #1;
        rst = 1'b0;
        for (int e = 1; e <= STAGES + 2; e++) begin
            step();
            check($sformatf("post_rst_valid_e%0d", e), 32'(bus.grant_valid),
                  (e == STAGES + 2) ? 32'd1 : 32'd0);
        end
        check("post_rst_idx", 32'(bus.grant_idx), 32'd2);
        bus.grant_ready = 1'b1;
        step();
        check("post_rst_ack", 32'(bus.ack), 32'b0100);
        bus.req_async = '0;
        wait_idle("post_rst_idle", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
